// File: rtl/fpga_io_pkg.sv
// Shared register map, CTRL layout and helpers for the board I/O controller.
package fpga_io_pkg;

    localparam logic [5:0] OFS_SW       = 6'h00;
    localparam logic [5:0] OFS_KEY      = 6'h04;
    localparam logic [5:0] OFS_KEY_EVT  = 6'h08;
    localparam logic [5:0] OFS_LED      = 6'h0C;
    localparam logic [5:0] OFS_LED_SET  = 6'h10;
    localparam logic [5:0] OFS_LED_CLR  = 6'h14;
    localparam logic [5:0] OFS_TICK_DIV = 6'h18;
    localparam logic [5:0] OFS_CTRL     = 6'h1C;
    localparam logic [5:0] OFS_STEP     = 6'h20;

    localparam int unsigned CTRL_RUN     = 0;
    localparam int unsigned CTRL_STEP_EN = 1;
    localparam int unsigned CTRL_IE_LSB  = 8;
    localparam int unsigned KEY_MAX      = 8;

    typedef struct packed {
        logic [KEY_MAX-1:0] key_ie;
        logic               step_en;
        logic               run;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{key_ie: '0, step_en: 1'b0, run: 1'b1};

    function automatic logic [31:0] ctrl_pack(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_RUN]                  = c.run;
        w[CTRL_STEP_EN]              = c.step_en;
        w[CTRL_IE_LSB +: KEY_MAX]    = c.key_ie;
        return w;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// One input channel: synchroniser chain, optional polarity flip, then a
// stable-level debouncer that also flags the accepted 0->1 transition.
module io_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 50000,
    parameter bit          INVERT      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   stable_q;
    logic                   rise_q;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1] ^ INVERT;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            rise_q <= 1'b0;
            if (level == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                // Mismatch has persisted DEB_CYCLES cycles: accept the new level.
                stable_q <= level;
                cnt_q    <= '0;
                rise_q   <= level;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign dout = stable_q;
    assign rise = rise_q;

endmodule

// File: rtl/fpga_io_ctrl.sv
// Memory-mapped board I/O: debounced switches/keys, key events with irq,
// LED register, and a programmable CPU clock-enable with run/step modes.
module fpga_io_ctrl
    import fpga_io_pkg::*;
#(
    parameter int unsigned N_SW           = 18,
    parameter int unsigned N_KEY          = 4,
    parameter int unsigned N_LED          = 18,
    parameter bit          KEY_ACTIVE_LOW = 1'b1,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEB_CYCLES     = 50000,
    parameter int unsigned TICK_DIV_RST   = 499999,
    parameter int unsigned STEP_KEY       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SW-1:0]  sw_pin,
    input  logic [N_KEY-1:0] key_pin,
    output logic [N_LED-1:0] led,
    input  logic [5:0]       bus_addr,
    input  logic             bus_we,
    input  logic             bus_re,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             cpu_ce,
    output logic             irq
);

    localparam logic [31:0]      TICK_RST = 32'(TICK_DIV_RST);
    localparam logic [KEY_MAX-1:0] IE_MASK = 8'((1 << N_KEY) - 1);

    logic [N_SW-1:0]  sw_db;
    logic [N_SW-1:0]  sw_rise;
    logic [N_KEY-1:0] key_db;
    logic [N_KEY-1:0] key_rise;
    logic             step_key_rise;

    for (genvar g = 0; g < N_SW; g++) begin : g_sw
        io_debounce #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_CYCLES (DEB_CYCLES),
            .INVERT     (1'b0)
        ) u_sw (
            .clk (clk),
            .rst (rst),
            .din (sw_pin[g]),
            .dout(sw_db[g]),
            .rise(sw_rise[g])
        );
    end

    for (genvar g = 0; g < N_KEY; g++) begin : g_key
        io_debounce #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_CYCLES (DEB_CYCLES),
            .INVERT     (KEY_ACTIVE_LOW)
        ) u_key (
            .clk (clk),
            .rst (rst),
            .din (key_pin[g]),
            .dout(key_db[g]),
            .rise(key_rise[g])
        );
    end

    if (STEP_KEY < N_KEY) begin : g_step_key
        assign step_key_rise = key_rise[STEP_KEY];
    end else begin : g_no_step_key
        assign step_key_rise = 1'b0;
    end

    logic unused_bits;
    assign unused_bits = ^{bus_addr[1:0], sw_rise};

    logic [5:0] ofs;
    logic       wr_evt, wr_led, wr_set, wr_clr, wr_div, wr_ctrl, wr_step;

    assign ofs     = {bus_addr[5:2], 2'b00};
    assign wr_evt  = bus_we && (ofs == OFS_KEY_EVT);
    assign wr_led  = bus_we && (ofs == OFS_LED);
    assign wr_set  = bus_we && (ofs == OFS_LED_SET);
    assign wr_clr  = bus_we && (ofs == OFS_LED_CLR);
    assign wr_div  = bus_we && (ofs == OFS_TICK_DIV);
    assign wr_ctrl = bus_we && (ofs == OFS_CTRL);
    assign wr_step = bus_we && (ofs == OFS_STEP);

    logic [N_LED-1:0] led_q, led_d;
    logic [N_KEY-1:0] key_evt_q, key_evt_d;
    logic [31:0]      tick_div_q, tick_div_d;
    logic [31:0]      tick_cnt_q, tick_cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             irq_q;
    logic [31:0]      rdata_q, rd_data;

    always_comb begin
        rd_data = '0;
        case (ofs)
            OFS_SW:       rd_data[N_SW-1:0]  = sw_db;
            OFS_KEY:      rd_data[N_KEY-1:0] = key_db;
            OFS_KEY_EVT:  rd_data[N_KEY-1:0] = key_evt_q;
            OFS_LED:      rd_data[N_LED-1:0] = led_q;
            OFS_TICK_DIV: rd_data            = tick_div_q;
            OFS_CTRL:     rd_data            = ctrl_pack(ctrl_q);
            default:      rd_data            = '0;
        endcase
    end

    always_comb begin
        led_d = led_q;
        if (wr_led) led_d = bus_wdata[N_LED-1:0];
        if (wr_set) led_d = led_q | bus_wdata[N_LED-1:0];
        if (wr_clr) led_d = led_q & ~bus_wdata[N_LED-1:0];

        // A new event in the same cycle as its clear must survive.
        key_evt_d = key_evt_q;
        if (wr_evt) key_evt_d = key_evt_q & ~bus_wdata[N_KEY-1:0];
        key_evt_d = key_evt_d | key_rise;

        tick_div_d = wr_div ? bus_wdata : tick_div_q;

        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d.run     = bus_wdata[CTRL_RUN];
            ctrl_d.step_en = bus_wdata[CTRL_STEP_EN];
            ctrl_d.key_ie  = bus_wdata[CTRL_IE_LSB +: KEY_MAX] & IE_MASK;
        end

        cpu_ce_d   = 1'b0;
        tick_cnt_d = tick_cnt_q;
        if (wr_div) begin
            tick_cnt_d = bus_wdata;
        end else if (wr_ctrl) begin
            tick_cnt_d = tick_div_q;
        end else if (ctrl_q.run) begin
            if (tick_cnt_q == '0) begin
                tick_cnt_d = tick_div_q;
                cpu_ce_d   = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q - 32'd1;
            end
        end else begin
            cpu_ce_d = wr_step | (step_key_rise & ctrl_q.step_en);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q      <= '0;
            key_evt_q  <= '0;
            tick_div_q <= TICK_RST;
            tick_cnt_q <= TICK_RST;
            ctrl_q     <= CTRL_RST;
            cpu_ce_q   <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            led_q      <= led_d;
            key_evt_q  <= key_evt_d;
            tick_div_q <= tick_div_d;
            tick_cnt_q <= tick_cnt_d;
            ctrl_q     <= ctrl_d;
            cpu_ce_q   <= cpu_ce_d;
            irq_q      <= |(key_evt_q & ctrl_q.key_ie[N_KEY-1:0]);
            if (bus_re) rdata_q <= rd_data;
        end
    end

    assign led       = led_q;
    assign bus_rdata = rdata_q;
    assign cpu_ce    = cpu_ce_q;
    assign irq       = irq_q;

endmodule
